// File: rtl/data_memory_responder.sv
// Fixed-latency byte-lane memory responder for the cache data-memory port.
// Accepts one 4-lane read or write at a time, completes it with a one-cycle mem_ready pulse.
module data_memory_responder #(
   parameter int unsigned ADDR_BITS = 16,
   parameter int unsigned LATENCY   = 4
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic        mem_write_en,
   input  logic [7:0]  mem_data_in  [0:3],
   output logic [7:0]  mem_data_out [0:3],
   output logic        mem_ready,
   output logic        mem_busy
);

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned DEPTH     = 1 << ADDR_BITS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic                   we_q;
   logic [7:0]             wdata_q  [NUM_LANES];
   logic [7:0]             rdata_q  [NUM_LANES];
   logic                   ready_q;
   logic                   busy_q;

   logic [7:0]             mem_q    [DEPTH];

   logic [ADDR_BITS-1:0]   base_addr;
   logic [ADDR_BITS-1:0]   lane_addr [NUM_LANES];
   logic [7:0]             rd_lanes  [NUM_LANES];
   logic                   unused_addr_hi;

   assign unused_addr_hi = ^mem_addr[31:ADDR_BITS];

   // In IDLE the live address is used so a LATENCY=1 read can complete on the acceptance edge.
   always_comb begin
      base_addr = (state_q == S_IDLE) ? mem_addr[ADDR_BITS-1:0] : addr_q;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_addr[i] = base_addr + ADDR_BITS'(i);
         rd_lanes[i]  = mem_q[lane_addr[i]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            rdata_q[i] <= 8'h00;
         end
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (mem_req) begin
                  addr_q  <= mem_addr[ADDR_BITS-1:0];
                  we_q    <= mem_write_en;
                  wdata_q <= mem_data_in;
                  busy_q  <= 1'b1;
                  if (LATENCY == 1) begin
                     state_q <= S_DONE;
                     ready_q <= 1'b1;
                     if (!mem_write_en) begin
                        rdata_q <= rd_lanes;
                     end
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_W'(LATENCY - 1);
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= S_DONE;
                  ready_q <= 1'b1;
                  if (!we_q) begin
                     rdata_q <= rd_lanes;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Store is never cleared; a reset on the DONE edge suppresses the commit.
   always_ff @(posedge clk) begin
      if (!rst_b && state_q == S_DONE && we_q) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            mem_q[lane_addr[i]] <= wdata_q[i];
         end
      end
   end

   assign mem_data_out = rdata_q;
   assign mem_ready    = ready_q;
   assign mem_busy     = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: default LATENCY=4 instance plus a LATENCY=1 instance.
module tb_data_memory_responder;

   logic        clk;
   logic        rst_b;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_write_en;
   logic [7:0]  din  [0:3];
   logic [7:0]  dout [0:3];
   logic        mem_ready;
   logic        mem_busy;

   logic        req1;
   logic [31:0] addr1;
   logic        we1;
   logic [7:0]  din1  [0:3];
   logic [7:0]  dout1 [0:3];
   logic        ready1;
   logic        busy1;

   int errs;
   int checks;

   data_memory_responder dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_write_en (mem_write_en),
      .mem_data_in  (din),
      .mem_data_out (dout),
      .mem_ready    (mem_ready),
      .mem_busy     (mem_busy)
   );

   data_memory_responder #(.ADDR_BITS(16), .LATENCY(1)) dut1 (
      .clk          (clk),
      .rst_b        (rst_b),
      .mem_req      (req1),
      .mem_addr     (addr1),
      .mem_write_en (we1),
      .mem_data_in  (din1),
      .mem_data_out (dout1),
      .mem_ready    (ready1),
      .mem_busy     (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dout_word();
      return {dout[3], dout[2], dout[1], dout[0]};
   endfunction

   task automatic preload(input logic [15:0] a, input logic [7:0] v);
      dut.mem_q[a]  = v;
      dut1.mem_q[a] = v;
   endtask

   // One transaction on the LATENCY=4 instance; returns cycles to mem_ready and lanes packed lane0-low.
   task automatic xact(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input bit disturb, output int lat, output logic [31:0] rdata);
      @(negedge clk);
      mem_req      = 1'b1;
      mem_addr     = addr;
      mem_write_en = we;
      for (int i = 0; i < 4; i++) din[i] = wdata[8*i +: 8];
      @(posedge clk);
      #1 mem_req = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (disturb && c == 1) begin
            mem_addr     = 32'h80;
            mem_write_en = ~we;
            mem_req      = 1'b1;
            for (int i = 0; i < 4; i++) din[i] = 8'h5A;
         end
         if (mem_ready) begin
            lat = c;
            break;
         end
      end
      mem_req = 1'b0;
      rdata   = dout_word();
   endtask

   int          lat;
   logic [31:0] rd;
   logic [31:0] rdy_vec;
   logic [31:0] exp_vec;
   logic        seen;

   initial begin
      errs = 0;
      checks = 0;
      rst_b = 1'b1;
      mem_req = 1'b0; mem_addr = '0; mem_write_en = 1'b0;
      req1 = 1'b0; addr1 = '0; we1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din[i] = 8'h00;
         din1[i] = 8'h00;
      end

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_busy", 32'(mem_busy), 32'd0);
      chk("rst_dout", dout_word(), 32'h0);
      rst_b = 1'b0;

      for (int i = 0; i < 4; i++) begin
         preload(16'h0100 + 16'(i), 8'h00);
         preload(16'h0040 + 16'(i), 8'h40 + 8'(i));
         preload(16'h0080 + 16'(i), 8'h80 + 8'(i));
         preload(16'h0300 + 16'(i), 8'h00);
         preload(16'h0310 + 16'(i), 8'h00);
      end
      for (int i = 0; i < 8; i++) preload(16'h0200 + 16'(i), 8'(i));
      preload(16'hFFFC, 8'hC0);
      preload(16'hFFFD, 8'hC1);
      preload(16'h0002, 8'h02);
      preload(16'h0003, 8'h03);

      // Read after write
      xact(32'h100, 1'b1, 32'h44332211, 1'b0, lat, rd);
      chk("wr_latency", 32'(lat), 32'd4);
      chk("wr_busy_at_ready", 32'(mem_busy), 32'd1);
      chk("wr_keeps_dout", rd, 32'h0);
      @(negedge clk);
      chk("ready_single_pulse", 32'(mem_ready), 32'd0);
      xact(32'h100, 1'b0, 32'h0, 1'b0, lat, rd);
      chk("rd_latency", 32'(lat), 32'd4);
      chk("raw_data", rd, 32'h44332211);

      // Misaligned read, then a write must leave mem_data_out alone
      xact(32'h203, 1'b0, 32'h0, 1'b0, lat, rd);
      chk("misaligned", rd, 32'h06050403);
      xact(32'h400, 1'b1, 32'hDEADBEEF, 1'b0, lat, rd);
      chk("write_hold_dout", rd, 32'h06050403);

      // Wrap at top of store and aliasing of upper address bits
      xact(32'hFFFE, 1'b1, 32'hA3A2A1A0, 1'b0, lat, rd);
      xact(32'hFFFC, 1'b0, 32'h0, 1'b0, lat, rd);
      chk("wrap_low", rd, 32'hA1A0C1C0);
      xact(32'h0000, 1'b0, 32'h0, 1'b0, lat, rd);
      chk("wrap_high", rd, 32'h0302A3A2);
      xact(32'h0001_0000, 1'b0, 32'h0, 1'b0, lat, rd);
      chk("alias", rd, 32'h0302A3A2);

      // Inputs changed while busy
      xact(32'h40, 1'b0, 32'h0, 1'b1, lat, rd);
      chk("busy_ignore_lat", 32'(lat), 32'd4);
      chk("busy_ignore_data", rd, 32'h43424140);
      xact(32'h80, 1'b0, 32'h0, 1'b0, lat, rd);
      chk("busy_no_write", rd, 32'h83828180);

      // Reset in WAIT at counter=2
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h300; mem_write_en = 1'b1;
      for (int i = 0; i < 4; i++) din[i] = 8'hFF;
      @(posedge clk);
      #1 mem_req = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      seen |= mem_ready;
      @(negedge clk);
      seen |= mem_ready;
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      chk("rst_mid_busy", 32'(mem_busy), 32'd0);
      chk("rst_mid_dout", dout_word(), 32'h0);
      for (int c = 0; c < 6; c++) begin
         seen |= mem_ready;
         @(negedge clk);
      end
      chk("rst_mid_no_ready", 32'(seen), 32'd0);
      xact(32'h300, 1'b0, 32'h0, 1'b0, lat, rd);
      chk("rst_mid_no_write", rd, 32'h0);

      // Reset coinciding with the DONE edge
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h310; mem_write_en = 1'b1;
      @(posedge clk);
      #1 mem_req = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mem_ready) begin
            lat = c;
            break;
         end
      end
      chk("rst_done_lat", 32'(lat), 32'd4);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      chk("rst_done_busy", 32'(mem_busy), 32'd0);
      xact(32'h310, 1'b0, 32'h0, 1'b0, lat, rd);
      chk("rst_done_no_write", rd, 32'h0);

      // Back-to-back with mem_req held, LATENCY=4
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h200; mem_write_en = 1'b0;
      rdy_vec = '0;
      exp_vec = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         rdy_vec[c] = mem_ready;
         exp_vec[c] = ((c % 5) == 4);
      end
      mem_req = 1'b0;
      chk("b2b_l4_pattern", rdy_vec, exp_vec);
      chk("b2b_l4_data", dout_word(), 32'h03020100);
      repeat (8) @(negedge clk);

      // Back-to-back with mem_req held, LATENCY=1
      req1 = 1'b1; addr1 = 32'h200; we1 = 1'b0;
      rdy_vec = '0;
      exp_vec = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         rdy_vec[c] = ready1;
         exp_vec[c] = ((c % 2) == 1);
         if (c == 1) begin
            chk("l1_data", {dout1[3], dout1[2], dout1[1], dout1[0]}, 32'h03020100);
            chk("l1_busy", 32'(busy1), 32'd1);
         end
      end
      req1 = 1'b0;
      chk("b2b_l1_pattern", rdy_vec, exp_vec);
      repeat (4) @(negedge clk);
      chk("l1_idle_busy", 32'(busy1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
